// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Logic, add/sub, shift and compare finish in one cycle;
// iterative shift-add MUL and restoring DIV are present only when ALU_MULDIV_EN is defined.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic             sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             ovf,
  output logic             neg,
  output logic             divz,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is taken on a rising edge where start=1 and the FSM is IDLE;
  // done then pulses for exactly one cycle with all results valid. start in any other state is dropped.

  localparam int MSB = WIDTH - 1;

  localparam logic [5:0] F_ADD  = 6'b000000;
  localparam logic [5:0] F_SUB  = 6'b000001;
  localparam logic [5:0] F_AND  = 6'b011000;
  localparam logic [5:0] F_OR   = 6'b011110;
  localparam logic [5:0] F_XOR  = 6'b010110;
  localparam logic [5:0] F_NOR  = 6'b010001;
  localparam logic [5:0] F_PASS = 6'b011010;
  localparam logic [5:0] F_SLL  = 6'b100000;
  localparam logic [5:0] F_SRL  = 6'b100001;
  localparam logic [5:0] F_SRA  = 6'b100011;
  localparam logic [5:0] F_EQ   = 6'b110011;
  localparam logic [5:0] F_NE   = 6'b110001;
  localparam logic [5:0] F_LT   = 6'b110101;
  localparam logic [5:0] F_LEZ  = 6'b111101;
  localparam logic [5:0] F_LTZ  = 6'b111011;
  localparam logic [5:0] F_GTZ  = 6'b111111;
`ifdef ALU_MULDIV_EN
  localparam logic [5:0] F_MUL  = 6'b001000;
  localparam logic [5:0] F_DIV  = 6'b001001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t state_q, state_d;

  logic             accept;
  logic             is_md;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sign;
  logic [SHW-1:0]   sh;
  logic             eq, lt;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_out;
  logic             sc_ovf, sc_valid;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;

`ifdef ALU_MULDIV_EN
  logic               is_mul, is_div;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic               rneg_q, rneg_d, aneg_q, aneg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               cnt_last;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;
  logic               div_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[MSB]) ? -x : x;
  endfunction

  assign is_mul  = (funct == F_MUL);
  assign is_div  = (funct == F_DIV);
  assign is_md   = is_mul | is_div;
  // Flags at the end of MUL/DIV come from the captured operands, not the live pins.
  assign op_a    = (state_q == S_IDLE) ? in1  : a_q;
  assign op_b    = (state_q == S_IDLE) ? in2  : b_q;
  assign op_sign = (state_q == S_IDLE) ? sign : sign_q;
`else
  assign is_md   = 1'b0;
  assign op_a    = in1;
  assign op_b    = in2;
  assign op_sign = sign;
`endif

  assign accept   = (state_q == S_IDLE) && start;
  assign sh       = op_a[SHW-1:0];
  assign eq       = (op_a == op_b);
  assign lt       = op_sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    sc_out   = '0;
    sc_ovf   = 1'b0;
    sc_valid = 1'b1;
    case (funct)
      F_ADD: begin
        sc_out = add_full[MSB:0];
        sc_ovf = op_sign ? ((op_a[MSB] == op_b[MSB]) && (add_full[MSB] != op_a[MSB]))
                         : add_full[WIDTH];
      end
      F_SUB: begin
        sc_out = sub_full[MSB:0];
        sc_ovf = op_sign ? ((op_a[MSB] != op_b[MSB]) && (sub_full[MSB] != op_a[MSB]))
                         : sub_full[WIDTH];
      end
      F_AND:  sc_out = op_a & op_b;
      F_OR:   sc_out = op_a | op_b;
      F_XOR:  sc_out = op_a ^ op_b;
      F_NOR:  sc_out = ~(op_a | op_b);
      F_PASS: sc_out = op_a;
      F_SLL:  sc_out = op_b << sh;
      F_SRL:  sc_out = op_b >> sh;
      F_SRA:  sc_out = $signed(op_b) >>> sh;
      F_EQ:   sc_out = WIDTH'(eq);
      F_NE:   sc_out = WIDTH'(!eq);
      F_LT:   sc_out = WIDTH'(lt);
      // Unsigned: nothing is below zero, so LEZ reduces to ==0 and GTZ to !=0.
      F_LEZ:  sc_out = WIDTH'(op_sign ? (op_a[MSB] || (op_a == '0)) : (op_a == '0));
      F_LTZ:  sc_out = WIDTH'(op_sign && op_a[MSB]);
      F_GTZ:  sc_out = WIDTH'(op_sign ? (!op_a[MSB] && (op_a != '0)) : (op_a != '0));
      default: sc_valid = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shift-add step: low half holds the remaining multiplier, high half the partial sum.
  assign cnt_last = (cnt_q == SHW'(WIDTH - 1));
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_next = {mul_sum, acc_q[MSB:1]};
  assign prod     = rneg_q ? -mul_next : mul_next;

  // Restoring step: remainder in the high half, dividend shifting out / quotient in the low half.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[MSB]};
  assign div_ge   = (rem_sh >= {1'b0, dvs_q});
  assign rem_new  = div_ge ? (rem_sh[MSB:0] - dvs_q) : rem_sh[MSB:0];
  assign div_next = {rem_new, acc_q[MSB-1:0], div_ge};
  assign quo      = div_next[MSB:0];
  assign rem      = div_next[2*WIDTH-1:WIDTH];
  assign div_lo   = (b_q == '0) ? '1  : (rneg_q ? -quo : quo);
  assign div_hi   = (b_q == '0) ? a_q : (aneg_q ? -rem : rem);
  assign div_ovf  = sign_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MULDIV_EN
          if (is_mul)      state_d = S_MUL;
          else if (is_div) state_d = S_DIV;
          else             state_d = S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      S_MUL, S_DIV: if (cnt_last) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
`ifdef ALU_MULDIV_EN
      S_MUL, S_DIV: busy = 1'b1;
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

  always_comb begin
    out_d  = out_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    neg_d  = neg_q;
`ifdef ALU_MULDIV_EN
    hi_d   = hi_q;
    lo_d   = lo_q;
    divz_d = divz_q;
    a_d    = a_q;
    b_d    = b_q;
    sign_d = sign_q;
    rneg_d = rneg_q;
    aneg_d = aneg_q;
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    cnt_d  = '0;
`endif
    if (accept) begin
`ifdef ALU_MULDIV_EN
      a_d    = in1;
      b_d    = in2;
      sign_d = sign;
      rneg_d = sign & (in1[MSB] ^ in2[MSB]);
      aneg_d = sign & in1[MSB];
      if (is_mul) begin
        acc_d = {{WIDTH{1'b0}}, mag(in2, sign)};
        dvs_d = mag(in1, sign);
      end
      if (is_div) begin
        acc_d = {{WIDTH{1'b0}}, mag(in1, sign)};
        dvs_d = mag(in2, sign);
      end
`endif
      if (!is_md) begin
        out_d  = sc_out;
        zero_d = sc_valid & eq;
        neg_d  = sc_valid & lt;
        ovf_d  = sc_ovf;
`ifdef ALU_MULDIV_EN
        divz_d = 1'b0;
`endif
      end
    end
`ifdef ALU_MULDIV_EN
    if (state_q == S_MUL || state_q == S_DIV) begin
      acc_d = (state_q == S_MUL) ? mul_next : div_next;
      cnt_d = cnt_q + SHW'(1);
      if (cnt_last) begin
        zero_d = eq;
        neg_d  = lt;
        if (state_q == S_MUL) begin
          hi_d   = prod[2*WIDTH-1:WIDTH];
          lo_d   = prod[MSB:0];
          out_d  = prod[MSB:0];
          ovf_d  = 1'b0;
          divz_d = 1'b0;
        end else begin
          hi_d   = div_hi;
          lo_d   = div_lo;
          out_d  = div_lo;
          ovf_d  = div_ovf;
          divz_d = (b_q == '0);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
      hi_q   <= '0;
      lo_q   <= '0;
      divz_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      rneg_q <= 1'b0;
      aneg_q <= 1'b0;
      acc_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      neg_q  <= neg_d;
`ifdef ALU_MULDIV_EN
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      divz_q <= divz_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sign_q <= sign_d;
      rneg_q <= rneg_d;
      aneg_q <= aneg_d;
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign neg  = neg_q;
`ifdef ALU_MULDIV_EN
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign divz = divz_q;
`else
  assign hi   = '0;
  assign lo   = '0;
  assign divz = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed vectors plus random operations against an
// arithmetic reference model; MUL/DIV expectations follow ALU_MULDIV_EN.
module tb_alu_mc;
  localparam int W = 32;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b011000;
  localparam logic [5:0] OP_OR   = 6'b011110;
  localparam logic [5:0] OP_XOR  = 6'b010110;
  localparam logic [5:0] OP_NOR  = 6'b010001;
  localparam logic [5:0] OP_PASS = 6'b011010;
  localparam logic [5:0] OP_SLL  = 6'b100000;
  localparam logic [5:0] OP_SRL  = 6'b100001;
  localparam logic [5:0] OP_SRA  = 6'b100011;
  localparam logic [5:0] OP_EQ   = 6'b110011;
  localparam logic [5:0] OP_NE   = 6'b110001;
  localparam logic [5:0] OP_LT   = 6'b110101;
  localparam logic [5:0] OP_LEZ  = 6'b111101;
  localparam logic [5:0] OP_LTZ  = 6'b111011;
  localparam logic [5:0] OP_GTZ  = 6'b111111;
  localparam logic [5:0] OP_MUL  = 6'b001000;
  localparam logic [5:0] OP_DIV  = 6'b001001;

`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic         clk = 1'b0;
  logic         reset, start, sign;
  logic [5:0]   funct;
  logic [W-1:0] in1, in2;
  logic         busy, done, zero, ovf, neg, divz;
  logic [W-1:0] out, hi, lo;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]     exp_q[$];
  logic [2*W+3:0]   aux_q[$];
  int               lat_q[$];
  logic [W-1:0]     m_hi = '0;
  logic [W-1:0]     m_lo = '0;

  logic [5:0] ops[18] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_PASS, OP_SLL, OP_SRL,
                          OP_SRA, OP_EQ, OP_NE, OP_LT, OP_LEZ, OP_LTZ, OP_GTZ, OP_MUL, OP_DIV};

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .sign(sign),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out), .hi(hi), .lo(lo),
    .zero(zero), .ovf(ovf), .neg(neg), .divz(divz), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
  task automatic model(input logic [5:0] f, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r, t;
    logic [63:0] p;
    logic [W-1:0] o, h, l;
    logic z, v, n, dz, valid;
    int lat, sh;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    sh = int'(a[4:0]);
    o = '0; v = 1'b0; dz = 1'b0; valid = 1'b1; lat = 1; h = m_hi; l = m_lo;
    case (f)
      OP_ADD: begin r = sa + sb; o = r[W-1:0]; v = s ? (r > SMAX || r < SMIN) : (r > UMAX); end
      OP_SUB: begin r = sa - sb; o = r[W-1:0]; v = s ? (r > SMAX || r < SMIN) : (r < 0); end
      OP_AND:  o = a & b;
      OP_OR:   o = a | b;
      OP_XOR:  o = a ^ b;
      OP_NOR:  o = ~(a | b);
      OP_PASS: o = a;
      OP_SLL:  o = b << sh;
      OP_SRL:  o = b >> sh;
      OP_SRA: begin t = longint'($signed(b)); t = t >>> sh; o = t[W-1:0]; end
      OP_EQ:  o = (a == b) ? 1 : 0;
      OP_NE:  o = (a != b) ? 1 : 0;
      OP_LT:  o = (sa < sb) ? 1 : 0;
      OP_LEZ: o = (s ? (sa <= 0) : (a == 0)) ? 1 : 0;
      OP_LTZ: o = (s && sa < 0) ? 1 : 0;
      OP_GTZ: o = (s ? (sa > 0) : (a != 0)) ? 1 : 0;
      OP_MUL: begin
        if (MD_EN) begin p = sa * sb; h = p[63:32]; l = p[31:0]; o = l; lat = 33; end
        else valid = 1'b0;
      end
      OP_DIV: begin
        if (MD_EN) begin
          lat = 33;
          if (b == 0) begin l = '1; h = a; dz = 1'b1; end
          else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = '0; v = 1'b1; end
          else begin r = sa / sb; t = sa % sb; l = r[W-1:0]; h = t[W-1:0]; end
          o = l;
        end else valid = 1'b0;
      end
      default: valid = 1'b0;
    endcase
    if (!valid) begin o = '0; v = 1'b0; end
    z = valid && (a == b);
    n = valid && (sa < sb);
    m_hi = h;
    m_lo = l;
    exp_q.push_back(o);
    aux_q.push_back({h, l, z, v, n, dz});
    lat_q.push_back(lat);
  endtask

  task automatic run_op(input logic [5:0] f, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit noise);
    logic [W-1:0]   eo;
    logic [2*W+3:0] ea;
    int el, n;
    bit seen;
    model(f, s, a, b);
    @(negedge clk);
    funct = f; sign = s; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = noise; funct = 6'($urandom); sign = 1'($urandom); in1 = $urandom; in2 = $urandom;
    eo = exp_q.pop_front();
    ea = aux_q.pop_front();
    el = lat_q.pop_front();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", busy, el > 1);
      if (done === 1'b1) seen = 1'b1;
      else if (noise) begin
        start = 1'($urandom); funct = 6'($urandom); in1 = $urandom; in2 = $urandom;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (!seen) return;
    check("latency", n, el);
    check("out", out, eo);
    check("hi", hi, ea[2*W+3:W+4]);
    check("lo", lo, ea[W+3:4]);
    check("zero", zero, ea[3]);
    check("ovf", ovf, ea[2]);
    check("neg", neg, ea[1]);
    check("divz", divz, ea[0]);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [5:0] f;
    reset = 1'b1; start = 1'b0; funct = '0; sign = 1'b0; in1 = '0; in2 = '0;
    @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_flags", {zero, ovf, neg, divz}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check("vec_add_out", out, 32'h8000_0000);
    check("vec_add_ovf", ovf, 1);
    run_op(OP_SRA, 1'b0, 32'd4, 32'hF000_0000, 1'b0);
    check("vec_sra", out, 32'hFF00_0000);
    run_op(OP_SLL, 1'b0, 32'd33, 32'h0000_0005, 1'b0);
    check("vec_sll33", out, 32'h0000_000A);
    run_op(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(OP_SUB, 1'b0, 32'd3, 32'd5, 1'b0);
    run_op(OP_LTZ, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(OP_GTZ, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(OP_LEZ, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(6'b000111, 1'b1, 32'd9, 32'd9, 1'b0);
    run_op(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1);
`ifdef ALU_MULDIV_EN
    check("vec_mul_hi", hi, 32'hFFFF_FFFF);
    check("vec_mul_lo", lo, 32'hFFFF_FFEB);
    run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("vec_div_lo", lo, 32'hFFFF_FFFD);
    check("vec_div_hi", hi, 32'hFFFF_FFFF);
    run_op(OP_DIV, 1'b0, 32'd5, 32'd0, 1'b0);
    check("vec_divz_lo", lo, 32'hFFFF_FFFF);
    check("vec_divz_hi", hi, 32'd5);
    check("vec_divz_flag", divz, 1);
    run_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`else
    check("vec_mul_off_out", out, 0);
    check("vec_mul_off_hilo", {hi, lo}, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      else f = ops[$urandom_range(0, 17)];
      run_op(f, 1'($urandom), rnd_operand(), rnd_operand(), 1'($urandom));
    end

    // Reset in the middle of an operation (or right after one when MUL/DIV is absent).
`ifdef ALU_MULDIV_EN
    @(negedge clk);
    funct = OP_DIV; sign = 1'b1; in1 = 32'd1000; in2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
`else
    run_op(OP_ADD, 1'b0, 32'd5, 32'd6, 1'b0);
`endif
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    check("abort_hilo", {hi, lo}, 0);
    check("abort_flags", {zero, ovf, neg, divz}, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    run_op(OP_ADD, 1'b1, 32'd20, 32'hFFFF_FFF6, 1'b0);
    check("post_reset_add", out, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
